// File: rtl/ctrl_jericalla_pkg.sv
// Shared definitions for the jericalla control sequencer: opcodes,
// instruction field positions and the FSM state encoding.
package jericalla_pkg;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_AND  = 3'b011;
  localparam logic [2:0] OP_OR   = 3'b100;
  localparam logic [2:0] OP_SLT  = 3'b101;
  localparam logic [2:0] OP_BZ   = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;

  localparam int OP_HI = 19;
  localparam int OP_LO = 17;
  localparam int RD_HI = 16;
  localparam int RD_LO = 12;
  localparam int RA_HI = 11;
  localparam int RA_LO = 7;
  localparam int RB_HI = 6;
  localparam int RB_LO = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_e;

endpackage

// File: rtl/ctrl_jericalla_dec.sv
// Combinational instruction decoder: splits the latched instruction into
// class flags and register/ALU fields.
module ctrl_dec_jericalla
  import jericalla_pkg::*;
(
  input  logic [19:0] ir,
  output logic        is_alu,
  output logic        is_bz,
  output logic        is_halt,
  output logic        is_nop,
  output logic [2:0]  alu_op,
  output logic [4:0]  ra,
  output logic [4:0]  rb,
  output logic [4:0]  rd
);

  logic [2:0] op;
  logic       unused_ir_bits;

  assign unused_ir_bits = ^ir[1:0];

  always_comb begin
    op      = ir[OP_HI:OP_LO];
    is_alu  = (op >= OP_ADD) && (op <= OP_SLT);
    is_bz   = (op == OP_BZ);
    is_halt = (op == OP_HALT);
    is_nop  = (op == OP_NOP);
    alu_op  = is_alu ? op : 3'b000;
    ra      = ir[RA_HI:RA_LO];
    rb      = ir[RB_HI:RB_LO];
    rd      = ir[RD_HI:RD_LO];
  end

endmodule

// File: rtl/ctrl_jericalla.sv
// Multicycle sequencer for the jericalla datapath: FETCH/DECODE/EXEC/WB
// phases, zero-flag branch and a start/busy/done handshake.
module ctrl_jericalla
  import jericalla_pkg::*;
#(
  parameter int PC_W    = 5,
  parameter int INSTR_W = 20,
  parameter int RA_W    = 5
) (
  input  logic               clk_ctrl_jericalla,
  input  logic               reset_ctrl_jericalla,
  input  logic               start_ctrl_jericalla,
  input  logic [INSTR_W-1:0] instr_ctrl_jericalla,
  input  logic               zf_ctrl_jericalla,
  output logic [PC_W-1:0]    imem_addr_ctrl_jericalla,
  output logic [RA_W-1:0]    ra_ctrl_jericalla,
  output logic [RA_W-1:0]    rb_ctrl_jericalla,
  output logic [RA_W-1:0]    wa_ctrl_jericalla,
  output logic               we_ctrl_jericalla,
  output logic [2:0]         alu_op_ctrl_jericalla,
  output logic               busy_ctrl_jericalla,
  output logic               done_ctrl_jericalla
);

  // Handshake: start is accepted only while busy is low (IDLE); once
  // accepted, busy stays high until the cycle after the one-cycle done pulse.
  state_e             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic               zflag_q, zflag_d;

  logic            dec_is_alu, dec_is_bz, dec_is_halt, dec_is_nop;
  logic [2:0]      dec_alu_op;
  logic [RA_W-1:0] dec_ra, dec_rb, dec_rd;

  ctrl_dec_jericalla u_dec (
    .ir      (ir_q),
    .is_alu  (dec_is_alu),
    .is_bz   (dec_is_bz),
    .is_halt (dec_is_halt),
    .is_nop  (dec_is_nop),
    .alu_op  (dec_alu_op),
    .ra      (dec_ra),
    .rb      (dec_rb),
    .rd      (dec_rd)
  );

  always_ff @(posedge clk_ctrl_jericalla or posedge reset_ctrl_jericalla) begin
    if (reset_ctrl_jericalla) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      zflag_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      zflag_q <= zflag_d;
    end
  end

  assign imem_addr_ctrl_jericalla = pc_q;
  assign busy_ctrl_jericalla      = (state_q != ST_IDLE);

  always_comb begin
    state_d               = state_q;
    pc_d                  = pc_q;
    ir_d                  = ir_q;
    zflag_d               = zflag_q;
    ra_ctrl_jericalla     = '0;
    rb_ctrl_jericalla     = '0;
    wa_ctrl_jericalla     = '0;
    we_ctrl_jericalla     = 1'b0;
    alu_op_ctrl_jericalla = 3'b000;
    done_ctrl_jericalla   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_ctrl_jericalla) begin
          pc_d    = '0;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH:  state_d = ST_DECODE;
      ST_DECODE: begin
        ir_d    = instr_ctrl_jericalla;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (dec_is_alu) begin
          ra_ctrl_jericalla     = dec_ra;
          rb_ctrl_jericalla     = dec_rb;
          alu_op_ctrl_jericalla = dec_alu_op;
          zflag_d               = zf_ctrl_jericalla;
          state_d               = ST_WB;
        end else if (dec_is_halt) begin
          state_d = ST_HALT;
        end else if (dec_is_nop || dec_is_bz) begin
          state_d = ST_FETCH;
          pc_d    = pc_q + PC_W'(1);
          if (dec_is_bz && zflag_q) pc_d = dec_rd;
        end
      end
      ST_WB: begin
        // Operand selects stay put so the datapath write data is stable.
        ra_ctrl_jericalla     = dec_ra;
        rb_ctrl_jericalla     = dec_rb;
        alu_op_ctrl_jericalla = dec_alu_op;
        wa_ctrl_jericalla     = dec_rd;
        we_ctrl_jericalla     = 1'b1;
        pc_d                  = pc_q + PC_W'(1);
        state_d               = ST_FETCH;
      end
      ST_HALT: begin
        done_ctrl_jericalla = 1'b1;
        state_d             = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ctrl_jericalla.sv
// Bench for ctrl_jericalla: an instruction-level reference model expands each
// program into a per-cycle expected output trace checked by a monitor.
module tb_ctrl_jericalla;

  localparam int W = 26;
  localparam logic [W-1:0] M_ALL      = '1;
  localparam logic [W-1:0] M_WA       = 26'h003E000;
  localparam logic [W-1:0] M_RARB     = 26'h0001FF8;
  localparam logic [W-1:0] M_EXEC_ALU = ~M_WA;
  localparam logic [W-1:0] M_EXEC_OTH = ~(M_WA | M_RARB);

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [19:0] instr = '0;
  logic        zf;
  logic [4:0]  imem_addr, ra, rb, wa;
  logic        we, busy, done;
  logic [2:0]  alu_op;

  logic [19:0] rom [32];
  logic        zf_force_en = 1'b0;
  logic        zf_force_val = 1'b0;
  logic [4:0]  m_pc = '0;
  logic        m_zflag = 1'b0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] mask_q[$];
  int checks = 0;
  int errors = 0;

  ctrl_jericalla dut (
    .clk_ctrl_jericalla       (clk),
    .reset_ctrl_jericalla     (rst),
    .start_ctrl_jericalla     (start),
    .instr_ctrl_jericalla     (instr),
    .zf_ctrl_jericalla        (zf),
    .imem_addr_ctrl_jericalla (imem_addr),
    .ra_ctrl_jericalla        (ra),
    .rb_ctrl_jericalla        (rb),
    .wa_ctrl_jericalla        (wa),
    .we_ctrl_jericalla        (we),
    .alu_op_ctrl_jericalla    (alu_op),
    .busy_ctrl_jericalla      (busy),
    .done_ctrl_jericalla      (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) instr <= rom[imem_addr];

  // Stand-in datapath zero flag, a fixed function of the operand selects.
  assign zf = zf_force_en ? zf_force_val : ((ra[1:0] == rb[1:0]) ^ alu_op[0]);

  function automatic logic model_zf(input logic [2:0] op, input logic [4:0] a, input logic [4:0] b);
    return zf_force_en ? zf_force_val : ((a[1:0] == b[1:0]) ^ op[0]);
  endfunction

  function automatic logic [19:0] enc(input logic [2:0] op, input logic [4:0] rd,
                                      input logic [4:0] a, input logic [4:0] b);
    return {op, rd, a, b, 2'b00};
  endfunction

  function automatic logic [W-1:0] pack(input logic b, input logic w, input logic d,
                                        input logic [4:0] addr, input logic [4:0] wad,
                                        input logic [4:0] a, input logic [4:0] bb,
                                        input logic [2:0] op);
    return {b, w, d, addr, wad, a, bb, op};
  endfunction

  task automatic push(input logic [W-1:0] v, input logic [W-1:0] m);
    exp_q.push_back(v);
    mask_q.push_back(m);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  // Monitor: every cycle with a pending expectation, compare the outputs.
  always @(negedge clk) begin
    logic [W-1:0] e, m, a;
    if (!rst && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      m = mask_q.pop_front();
      a = {busy, we, done, imem_addr, wa, ra, rb, alu_op};
      checks++;
      if ((a & m) !== (e & m)) begin
        errors++;
        $display("FAIL trace @%0t: got %07h, expected %07h (mask %07h)", $time, a, e, m);
      end
    end
  end

  // Instruction-level model: one IDLE(start) cycle, then per-instruction
  // cycle patterns derived from the phase rules.
  task automatic model_run(input int max_cyc, input int trail, output int n_busy, output bit halted);
    int pc;
    logic [19:0] ins;
    logic [2:0] op;
    logic [4:0] rd, fa, fb;
    push(pack(1'b0, 1'b0, 1'b0, m_pc, 5'd0, 5'd0, 5'd0, 3'd0), M_ALL);
    pc = 0;
    n_busy = 0;
    halted = 1'b0;
    while (!halted && n_busy < max_cyc) begin
      ins = rom[pc];
      op = ins[19:17];
      rd = ins[16:12];
      fa = ins[11:7];
      fb = ins[6:2];
      push(pack(1'b1, 1'b0, 1'b0, 5'(pc), 5'd0, 5'd0, 5'd0, 3'd0), M_ALL);
      push(pack(1'b1, 1'b0, 1'b0, 5'(pc), 5'd0, 5'd0, 5'd0, 3'd0), M_ALL);
      n_busy += 2;
      if (op >= 3'd1 && op <= 3'd5) begin
        push(pack(1'b1, 1'b0, 1'b0, 5'(pc), 5'd0, fa, fb, op), M_EXEC_ALU);
        push(pack(1'b1, 1'b1, 1'b0, 5'(pc), rd, fa, fb, op), M_ALL);
        m_zflag = model_zf(op, fa, fb);
        n_busy += 2;
        pc = (pc + 1) % 32;
      end else if (op == 3'd7) begin
        push(pack(1'b1, 1'b0, 1'b0, 5'(pc), 5'd0, 5'd0, 5'd0, 3'd0), M_EXEC_OTH);
        push(pack(1'b1, 1'b0, 1'b1, 5'(pc), 5'd0, 5'd0, 5'd0, 3'd0), M_ALL);
        n_busy += 2;
        halted = 1'b1;
      end else begin
        push(pack(1'b1, 1'b0, 1'b0, 5'(pc), 5'd0, 5'd0, 5'd0, 3'd0), M_EXEC_OTH);
        n_busy += 1;
        if (op == 3'd6 && m_zflag) pc = int'(rd);
        else pc = (pc + 1) % 32;
      end
    end
    m_pc = 5'(pc);
    if (halted)
      for (int i = 0; i < trail; i++)
        push(pack(1'b0, 1'b0, 1'b0, m_pc, 5'd0, 5'd0, 5'd0, 3'd0), M_ALL);
  endtask

  task automatic wait_drain();
    int b = 0;
    while (exp_q.size() != 0 && b < 400) begin
      @(posedge clk); #1;
      b++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expected cycles never observed, required 0", exp_q.size());
      exp_q.delete();
      mask_q.delete();
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    start = 1'b0;
    rst = 1'b1;
    #1;
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_we", 32'(we), 32'd0);
    chk("async_rst_done", 32'(done), 32'd0);
    chk("async_rst_addr", 32'(imem_addr), 32'd0);
    exp_q.delete();
    mask_q.delete();
    m_pc = '0;
    m_zflag = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++)
      push(pack(1'b0, 1'b0, 1'b0, m_pc, 5'd0, 5'd0, 5'd0, 3'd0), M_ALL);
  endtask

  task automatic run_prog(input int max_cyc, input int trail, input bit rand_start);
    int n_busy;
    bit halted;
    @(posedge clk); #1;
    start = 1'b1;
    model_run(max_cyc, trail, n_busy, halted);
    for (int k = 1; k <= n_busy + (halted ? trail : 0); k++) begin
      @(posedge clk); #1;
      start = (rand_start && k <= n_busy) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    wait_drain();
    start = 1'b0;
    if (!halted) do_reset();
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 32; i++) rom[i] = '0;
  endtask

  initial begin
    int b;
    int nb;
    bit h;
    clear_rom();

    // Reset state and quiet idle before any start.
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_we", 32'(we), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_addr", 32'(imem_addr), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    push_idle(4);
    wait_drain();

    // ADD then HALT.
    rom[0] = enc(3'd1, 5'd3, 5'd1, 5'd2);
    rom[1] = enc(3'd7, 5'd0, 5'd0, 5'd0);
    run_prog(200, 2, 1'b0);

    // Reset asserted while we is high must drop we without a clock edge.
    @(posedge clk); #1;
    start = 1'b1;
    model_run(200, 0, nb, h);
    @(posedge clk); #1;
    start = 1'b0;
    b = 0;
    @(negedge clk);
    while (we !== 1'b1 && b < 20) begin
      @(negedge clk);
      b++;
    end
    chk("wb_reached", 32'(we), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("midwb_we", 32'(we), 32'd0);
    chk("midwb_busy", 32'(busy), 32'd0);
    chk("midwb_done", 32'(done), 32'd0);
    chk("midwb_addr", 32'(imem_addr), 32'd0);
    chk("midwb_wa", 32'(wa), 32'd0);
    exp_q.delete();
    mask_q.delete();
    m_pc = '0;
    m_zflag = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    push_idle(5);
    wait_drain();

    // SUB sets zflag, BZ taken to 7.
    clear_rom();
    rom[0] = enc(3'd2, 5'd4, 5'd5, 5'd5);
    rom[1] = enc(3'd6, 5'd7, 5'd0, 5'd0);
    rom[7] = enc(3'd7, 5'd0, 5'd0, 5'd0);
    zf_force_en = 1'b1;
    zf_force_val = 1'b1;
    run_prog(200, 2, 1'b0);

    // Same program, zflag clear: BZ falls through to 2.
    rom[2] = enc(3'd7, 5'd0, 5'd0, 5'd0);
    zf_force_val = 1'b0;
    run_prog(200, 2, 1'b0);
    zf_force_en = 1'b0;

    // All NOPs with junk in the ignored bits: 33 fetches cover the PC wrap.
    for (int i = 0; i < 32; i++) rom[i] = {3'b000, 17'($urandom)};
    run_prog(99, 0, 1'b1);

    // start held high with a lone HALT: back-to-back 5-cycle runs.
    clear_rom();
    rom[0] = enc(3'd7, 5'd0, 5'd0, 5'd0);
    @(posedge clk); #1;
    start = 1'b1;
    for (int r = 0; r < 4; r++) model_run(10, 0, nb, h);
    wait_drain();
    start = 1'b0;
    push_idle(2);
    wait_drain();

    // Random programs with random start activity while busy.
    for (int p = 0; p < 25; p++) begin
      for (int i = 0; i < 32; i++) rom[i] = 20'($urandom_range(0, 20'hFFFFF));
      run_prog(150, 2, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
